// File: rtl/seq_gen.sv
// Pattern source: emits 1-2-1-3-1 (ASCII) num_seq times over a valid/ready stream,
// with gap_len fill symbols ("0") between consecutive patterns.
module seq_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_seq,
  input  logic [CNT_W-1:0]      gap_len,
  input  logic                  abort,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_symbol,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  localparam logic [DATA_WIDTH-1:0] S1   = DATA_WIDTH'(8'h31);
  localparam logic [DATA_WIDTH-1:0] S2   = DATA_WIDTH'(8'h32);
  localparam logic [DATA_WIDTH-1:0] S3   = DATA_WIDTH'(8'h33);
  localparam logic [DATA_WIDTH-1:0] FILL = DATA_WIDTH'(8'h30);
  localparam logic [CNT_W-1:0]      ONE  = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [2:0]              sym_idx_q, sym_idx_d;
  logic [CNT_W-1:0]        seq_cnt_q, seq_cnt_d;
  logic [CNT_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]        num_seq_q, num_seq_d;
  logic [CNT_W-1:0]        gap_len_q, gap_len_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_symbol_q, out_symbol_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    xfer;

  function automatic logic [DATA_WIDTH-1:0] sym_of(input logic [2:0] idx);
    case (idx)
      3'd1:    sym_of = S2;
      3'd3:    sym_of = S3;
      default: sym_of = S1;
    endcase
  endfunction

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    sym_idx_d    = sym_idx_q;
    seq_cnt_d    = seq_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    num_seq_d    = num_seq_q;
    gap_len_d    = gap_len_q;
    out_valid_d  = out_valid_q;
    out_symbol_d = out_symbol_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_seq_d = num_seq;
          gap_len_d = gap_len;
          sym_idx_d = 3'd0;
          seq_cnt_d = '0;
          gap_cnt_d = '0;
          if (num_seq != '0) begin
            state_d      = SEND;
            out_valid_d  = 1'b1;
            out_symbol_d = S1;
            busy_d       = 1'b1;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        // abort wins over a concurrent transfer: that last symbol is taken, nothing follows
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (xfer) begin
          if (sym_idx_q == 3'd4) begin
            if (seq_cnt_q + ONE == num_seq_q) begin
              state_d     = FIN;
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end else if (gap_len_q != '0) begin
              state_d      = GAP;
              gap_cnt_d    = '0;
              seq_cnt_d    = seq_cnt_q + ONE;
              out_symbol_d = FILL;
            end else begin
              sym_idx_d    = 3'd0;
              seq_cnt_d    = seq_cnt_q + ONE;
              out_symbol_d = S1;
            end
          end else begin
            sym_idx_d    = sym_idx_q + 3'd1;
            out_symbol_d = sym_of(sym_idx_q + 3'd1);
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (xfer) begin
          if (gap_cnt_q == gap_len_q - ONE) begin
            state_d      = SEND;
            sym_idx_d    = 3'd0;
            out_symbol_d = S1;
          end else begin
            gap_cnt_d = gap_cnt_q + ONE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sym_idx_q    <= 3'd0;
      seq_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      num_seq_q    <= '0;
      gap_len_q    <= '0;
      out_valid_q  <= 1'b0;
      out_symbol_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_idx_q    <= sym_idx_d;
      seq_cnt_q    <= seq_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      num_seq_q    <= num_seq_d;
      gap_len_q    <= gap_len_d;
      out_valid_q  <= out_valid_d;
      out_symbol_q <= out_symbol_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_symbol = out_symbol_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: expected symbols are queued as each run is started
// and popped by a monitor on every observed transfer.
module tb_seq_gen;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, out_ready;
  logic [CW-1:0] num_seq, gap_len;
  logic          out_valid, busy, done;
  logic [DW-1:0] out_symbol;

  seq_gen #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_seq(num_seq),
    .gap_len(gap_len), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .out_symbol(out_symbol), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pat();
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h31);
    exp_q.push_back(8'h33); exp_q.push_back(8'h31);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Monitor: scoreboard pop on transfer, stall stability, busy/done exclusivity
  logic       pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [7:0] ps = 8'h0;
  always @(negedge clk) begin
    if (!reset_n) begin
      pv <= 1'b0;
    end else begin
      if (pv && !pr && !pa) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_symbol", 32'(out_symbol), 32'(ps));
      end
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) done_cnt <= done_cnt + 1;
      if (out_valid && out_ready) begin
        xfer_cnt <= xfer_cnt + 1;
        if (exp_q.size() == 0) chk("unexpected_xfer", 32'(out_symbol), 32'hFFFF_FFFF);
        else chk("symbol", 32'(out_symbol), 32'(exp_q.pop_front()));
      end
      pv <= out_valid;
      pr <= out_ready;
      pa <= abort;
      ps <= out_symbol;
    end
  end

  int x0, d0, n;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    num_seq = '0; gap_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_symbol", 32'(out_symbol), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single pattern, always ready
    x0 = xfer_cnt; d0 = done_cnt;
    push_pat();
    out_ready = 1'b1; num_seq = 8'd1; gap_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_first_sym", 32'(out_symbol), 32'h31);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    chk("t1_no_early_done", 32'(done), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_valid_end", 32'(out_valid), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_xfers", 32'(xfer_cnt - x0), 32'd5);
    chk("t1_dones", 32'(done_cnt - d0), 32'd1);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // 2: three patterns with two fill symbols between
    x0 = xfer_cnt; d0 = done_cnt;
    push_pat(); exp_q.push_back(8'h30); exp_q.push_back(8'h30);
    push_pat(); exp_q.push_back(8'h30); exp_q.push_back(8'h30);
    push_pat();
    num_seq = 8'd3; gap_len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t2_done");
    tick();
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd19);
    chk("t2_dones", 32'(done_cnt - d0), 32'd1);
    chk("t2_queue", 32'(exp_q.size()), 32'd0);

    // 3: two patterns, ready toggling every cycle
    x0 = xfer_cnt;
    push_pat(); push_pat();
    num_seq = 8'd2; gap_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("t3_done", 32'(done), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t3_xfers", 32'(xfer_cnt - x0), 32'd10);
    chk("t3_queue", 32'(exp_q.size()), 32'd0);

    // 4: zero-length run
    x0 = xfer_cnt;
    num_seq = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_done_pulse", 32'(done), 32'd0);
    chk("t4_valid2", 32'(out_valid), 32'd0);
    chk("t4_xfers", 32'(xfer_cnt - x0), 32'd0);

    // 5: reset after third transfer, then a fresh run
    x0 = xfer_cnt; d0 = done_cnt;
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h31);
    num_seq = 8'd1; gap_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) tick();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_xfers", 32'(xfer_cnt - x0), 32'd3);
    chk("t5_queue", 32'(exp_q.size()), 32'd0);
    x0 = xfer_cnt;
    push_pat();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_restart_sym", 32'(out_symbol), 32'h31);
    wait_done("t5_done");
    tick();
    chk("t5_rerun_xfers", 32'(xfer_cnt - x0), 32'd5);

    // 6: start ignored mid-run, then abort after the seventh transfer
    x0 = xfer_cnt; d0 = done_cnt;
    push_pat(); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    num_seq = 8'd2; gap_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; num_seq = 8'd5; gap_len = 8'd3;
    repeat (2) tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1; out_ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_xfers", 32'(xfer_cnt - x0), 32'd7);
    chk("t6_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
